// File: rtl/btn_move_fsm.sv
// Debounced direction-button decoder: turns one held active-low button into
// valid/ready move events, with optional auto-repeat while the button stays down.
module btn_move_fsm #(
  parameter int N_BTN     = 4,
  parameter int DEB_CYC   = 16,
  parameter int REPEAT_EN = 0,
  parameter int REP_DLY   = 1000,
  parameter int REP_PER   = 250,
  localparam int MW       = $clog2(N_BTN + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_BTN-1:0] btn_n,
  input  logic             move_ready,
  output logic             move_valid,
  output logic [MW-1:0]    movement
);

  localparam int CW      = (N_BTN > 1) ? $clog2(N_BTN) : 1;
  localparam int DW      = $clog2(DEB_CYC) + 1;
  localparam int REP_MAX = (REP_DLY > REP_PER) ? REP_DLY : REP_PER;
  localparam int RW      = $clog2(REP_MAX) + 1;

  localparam logic [DW-1:0] DEB_LIM = DW'(DEB_CYC);
  localparam logic [RW-1:0] DLY_LIM = RW'(REP_DLY);
  localparam logic [RW-1:0] PER_LIM = RW'(REP_PER);

  typedef enum logic [2:0] {
    IDLE,
    DEBOUNCE,
    PRESS,
    HOLD,
    RELEASE
  } state_e;

  state_e            state_q, state_d;
  logic [N_BTN-1:0]  sync1_q, sync1_d;
  logic [N_BTN-1:0]  sync2_q, sync2_d;
  logic [CW-1:0]     cand_q, cand_d;
  logic [DW-1:0]     deb_cnt_q, deb_cnt_d;
  logic [RW-1:0]     rep_cnt_q, rep_cnt_d;
  logic              first_rep_q, first_rep_d;

  logic              any_low;
  logic [CW-1:0]     low_idx;
  logic              cand_high;
  logic [DW-1:0]     deb_inc;
  logic [RW-1:0]     rep_inc;
  logic [RW-1:0]     rep_lim;

  always_comb begin
    sync1_d = btn_n;
    sync2_d = sync1_q;
  end

  always_comb begin
    any_low = 1'b0;
    low_idx = '0;
    for (int unsigned i = 0; i < N_BTN; i++) begin
      if (!sync2_q[i] && !any_low) begin
        any_low = 1'b1;
        low_idx = CW'(i);
      end
    end
  end

  // Saturating increments: counters stop at all-ones instead of wrapping.
  always_comb begin
    cand_high = sync2_q[cand_q];
    deb_inc   = (deb_cnt_q == '1) ? deb_cnt_q : deb_cnt_q + DW'(1);
    rep_inc   = (rep_cnt_q == '1) ? rep_cnt_q : rep_cnt_q + RW'(1);
    rep_lim   = first_rep_q ? DLY_LIM : PER_LIM;
  end

  always_comb begin
    state_d     = state_q;
    cand_d      = cand_q;
    deb_cnt_d   = deb_cnt_q;
    rep_cnt_d   = rep_cnt_q;
    first_rep_d = first_rep_q;
    unique case (state_q)
      IDLE: begin
        if (any_low) begin
          cand_d    = low_idx;
          deb_cnt_d = DW'(1);
          state_d   = DEBOUNCE;
        end
      end
      DEBOUNCE: begin
        if (cand_high) begin
          deb_cnt_d = '0;
          state_d   = IDLE;
        end else begin
          deb_cnt_d = deb_inc;
          if (deb_inc >= DEB_LIM) begin
            first_rep_d = 1'b1;
            state_d     = PRESS;
          end
        end
      end
      PRESS: begin
        if (move_ready) begin
          rep_cnt_d = '0;
          state_d   = HOLD;
        end
      end
      HOLD: begin
        if (cand_high) begin
          deb_cnt_d = DW'(1);
          state_d   = RELEASE;
        end else if (REPEAT_EN != 0) begin
          rep_cnt_d = rep_inc;
          if (rep_inc >= rep_lim) begin
            first_rep_d = 1'b0;
            state_d     = PRESS;
          end
        end
      end
      RELEASE: begin
        // A bounce back to low re-arms the full initial repeat delay.
        if (!cand_high) begin
          rep_cnt_d   = '0;
          first_rep_d = 1'b1;
          state_d     = HOLD;
        end else begin
          deb_cnt_d = deb_inc;
          if (deb_inc >= DEB_LIM) begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q     <= '1;
      sync2_q     <= '1;
      state_q     <= IDLE;
      cand_q      <= '0;
      deb_cnt_q   <= '0;
      rep_cnt_q   <= '0;
      first_rep_q <= 1'b1;
    end else begin
      sync1_q     <= sync1_d;
      sync2_q     <= sync2_d;
      state_q     <= state_d;
      cand_q      <= cand_d;
      deb_cnt_q   <= deb_cnt_d;
      rep_cnt_q   <= rep_cnt_d;
      first_rep_q <= first_rep_d;
    end
  end

  always_comb begin
    move_valid = (state_q == PRESS);
    movement   = '0;
    if (state_q == PRESS || state_q == HOLD || state_q == RELEASE) begin
      movement = MW'(cand_q) + MW'(1);
    end
  end

endmodule

// File: tb/tb_btn_move_fsm.sv
// Bench for btn_move_fsm: one instance without and one with auto-repeat,
// both compared every cycle against an event-level model of button behaviour.
module tb_btn_move_fsm;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] btn_n;
  logic       move_ready;

  logic       valid0, valid1;
  logic [2:0] mov0, mov1;

  always #5 clk = ~clk;

  btn_move_fsm #(
    .N_BTN    (4),
    .DEB_CYC  (4),
    .REPEAT_EN(0)
  ) dut0 (
    .clk       (clk),
    .rst       (rst),
    .btn_n     (btn_n),
    .move_ready(move_ready),
    .move_valid(valid0),
    .movement  (mov0)
  );

  btn_move_fsm #(
    .N_BTN    (4),
    .DEB_CYC  (4),
    .REPEAT_EN(1),
    .REP_DLY  (20),
    .REP_PER  (8)
  ) dut1 (
    .clk       (clk),
    .rst       (rst),
    .btn_n     (btn_n),
    .move_ready(move_ready),
    .move_valid(valid1),
    .movement  (mov1)
  );

  int n_chk  = 0;
  int n_pass = 0;
  int cyc    = 0;
  bit chk_en = 0;

  // Model: which button is being tracked, whether it has been confirmed,
  // whether an event is pending, and run lengths of samples / held cycles.
  localparam int DEB = 4;
  int   rep_en [2] = '{0, 1};
  int   dly    [2] = '{20, 20};
  int   per    [2] = '{8, 8};
  int   m_cand [2];
  bit   m_conf [2];
  bit   m_pend [2];
  int   m_run  [2];
  int   m_held [2];
  int   m_gap  [2];
  logic [3:0] m_s1, m_s2;
  int   exp_valid [2];
  int   exp_mov   [2];

  task automatic chk(input string name, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, got, exp, cyc);
  endtask

  task automatic model_update();
    cyc++;
    for (int k = 0; k < 2; k++) begin
      if (rst) begin
        m_cand[k] = -1; m_conf[k] = 0; m_pend[k] = 0;
        m_run[k]  = 0;  m_held[k] = 0; m_gap[k]  = dly[k];
      end else if (m_cand[k] < 0) begin
        for (int b = 3; b >= 0; b--) if (!m_s2[b]) m_cand[k] = b;
        m_run[k] = 1;
      end else if (!m_conf[k]) begin
        if (m_s2[m_cand[k]]) begin
          m_cand[k] = -1;
        end else begin
          m_run[k]++;
          if (m_run[k] == DEB) begin
            m_conf[k] = 1; m_pend[k] = 1; m_run[k] = 0; m_gap[k] = dly[k];
          end
        end
      end else if (m_pend[k]) begin
        if (move_ready) begin m_pend[k] = 0; m_held[k] = 0; end
      end else if (m_run[k] == 0) begin
        if (m_s2[m_cand[k]]) m_run[k] = 1;
        else if (rep_en[k] != 0) begin
          m_held[k]++;
          if (m_held[k] == m_gap[k]) begin m_pend[k] = 1; m_gap[k] = per[k]; end
        end
      end else begin
        if (!m_s2[m_cand[k]]) begin
          m_run[k] = 0; m_held[k] = 0; m_gap[k] = dly[k];
        end else begin
          m_run[k]++;
          if (m_run[k] == DEB) begin m_cand[k] = -1; m_conf[k] = 0; m_run[k] = 0; end
        end
      end
      exp_valid[k] = m_pend[k] ? 1 : 0;
      exp_mov[k]   = (m_cand[k] >= 0 && m_conf[k]) ? m_cand[k] + 1 : 0;
    end
    if (rst) begin m_s1 = '1; m_s2 = '1; end
    else begin m_s2 = m_s1; m_s1 = btn_n; end
  endtask

  task automatic step();
    @(posedge clk);
    model_update();
    @(negedge clk);
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("valid_norep", int'(valid0), exp_valid[0]);
      chk("move_norep",  int'(mov0),   exp_mov[0]);
      chk("valid_rep",   int'(valid1), exp_valid[1]);
      chk("move_rep",    int'(mov1),   exp_mov[1]);
    end
  end

  initial begin
    int base;
    int nval;
    int vt[$];
    for (int k = 0; k < 2; k++) begin
      m_cand[k] = -1; m_conf[k] = 0; m_pend[k] = 0;
      m_run[k] = 0; m_held[k] = 0; m_gap[k] = dly[k];
      exp_valid[k] = 0; exp_mov[k] = 0;
    end
    m_s1 = '1; m_s2 = '1;
    rst = 1'b1; btn_n = '1; move_ready = 1'b1;
    @(negedge clk);
    step();
    chk_en = 1;
    step(); step();
    chk("reset_valid", int'(valid0), 0);
    chk("reset_move",  int'(mov0),   0);
    rst = 1'b0;

    // Press detection: bit 1 low from edge 1.
    base = cyc; btn_n = 4'b1101; nval = 0;
    for (int k = 1; k <= 12; k++) begin
      step();
      nval += int'(valid0);
      if (k == 5) chk("press_lat_before", int'(valid0), 0);
      if (k == 6) begin
        chk("press_lat_valid", int'(valid0), 1);
        chk("press_lat_model", exp_valid[0], 1);
        chk("press_move", int'(mov0), 2);
      end
      if (k == 7) chk("press_one_cycle", int'(valid0), 0);
      if (k == 12) chk("hold_move", int'(mov0), 2);
    end
    chk("press_count", nval, 1);
    btn_n = '1;
    for (int k = 1; k <= 8; k++) begin
      step();
      if (k == 5) chk("release_move_kept", int'(mov0), 2);
      if (k == 6) begin
        chk("release_move_zero", int'(mov0), 0);
        chk("release_model_zero", exp_mov[0], 0);
      end
    end

    // Glitch rejection: 3 low samples are not enough.
    btn_n = 4'b1110; nval = 0;
    for (int k = 1; k <= 13; k++) begin
      step();
      if (k == 3) btn_n = '1;
      nval += int'(valid0) + int'(mov0 != 0);
    end
    chk("glitch_ignored", nval, 0);

    // Simultaneous presses: lowest index wins, later bit-3 press ignored.
    btn_n = 4'b0110; nval = 0;
    for (int k = 1; k <= 28; k++) begin
      step();
      nval += int'(valid0);
      if (k == 6) chk("simul_move", int'(mov0), 1);
      if (k == 12) btn_n = 4'b1110;
      if (k == 18) btn_n = 4'b0110;
    end
    chk("simul_move_late", int'(mov0), 1);
    chk("simul_count", nval, 1);
    btn_n = '1;
    repeat (12) step();
    chk("simul_idle", int'(mov0), 0);

    // Backpressure with release while waiting.
    move_ready = 1'b0; btn_n = 4'b1011;
    repeat (6) step();
    chk("bp_valid", int'(valid0), 1);
    btn_n = '1;
    for (int k = 1; k <= 5; k++) begin
      step();
      chk("bp_valid_held", int'(valid0), 1);
      chk("bp_move_held", int'(mov0), 3);
    end
    move_ready = 1'b1;
    step();
    chk("bp_transfer", int'(valid0), 0);
    chk("bp_hold_move", int'(mov0), 3);
    repeat (4) step();
    chk("bp_idle", int'(mov0), 0);
    repeat (6) step();

    // Auto-repeat on the repeat-enabled instance.
    base = cyc; btn_n = 4'b1011;
    for (int k = 1; k <= 100; k++) begin
      step();
      if (k == 80) btn_n = '1;
      if (valid1) begin
        vt.push_back(cyc - base);
        chk("rep_move", int'(mov1), 3);
      end
    end
    chk("rep_count", vt.size(), 8);
    for (int i = 0; i < vt.size() && i < 8; i++)
      chk("rep_time", vt[i], (i == 0) ? 6 : 27 + 9 * (i - 1));

    // Reset while an event is offered.
    move_ready = 1'b0; btn_n = 4'b1101;
    repeat (6) step();
    chk("rst_pre_valid", int'(valid0), 1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("rst_valid", int'(valid0), 0);
    chk("rst_move", int'(mov0), 0);
    base = cyc;
    for (int k = 1; k <= 6; k++) begin
      step();
      if (k == 5) chk("rst_relat_before", int'(valid0), 0);
      if (k == 6) begin
        chk("rst_relat_valid", int'(valid0), 1);
        chk("rst_relat_move", int'(mov0), 2);
      end
    end
    move_ready = 1'b1; btn_n = '1;
    repeat (12) step();

    // Random phase.
    for (int it = 0; it < 150; it++) begin
      int sel = $urandom_range(0, 9);
      int len = $urandom_range(1, 40);
      if (sel < 3) btn_n = '1;
      else if (sel < 8) begin
        btn_n = '1;
        btn_n[$urandom_range(0, 3)] = 1'b0;
      end else btn_n = 4'($urandom);
      for (int j = 0; j < len; j++) begin
        move_ready = ($urandom_range(0, 3) != 0);
        rst = ($urandom_range(0, 199) == 0);
        step();
      end
    end
    rst = 1'b0;
    step();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
